mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shared word-addressed data memory serving NUM_PORTS requesters (fetch, load/store, and later a debug or DMA port) through one physical access slot per cycle.
- Replaces the fixed two-read, one-write RAM arrangement with a valid/ready request interface, round-robin arbitration, byte-enabled writes and a configurable read latency.
- Sits between the pipeline stages (fetch, mem) and the backing storage inside the core top level.

Parameters:
- NUM_PORTS, 2, number of requester ports; legal range 1..4.
- ADDR_W, 30, word address width per port.
- DATA_W, 32, data width; must be a multiple of 8.
- DEPTH_LOG2, 12, storage depth is 2^DEPTH_LOG2 words.
- RD_LAT, 1, read latency in cycles from handshake to response; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port grant; combinational from req_valid and the arbitration state.
- req_we  in  NUM_PORTS  per-port write flag; 1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  flattened word addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  flattened write data.
- req_be  in  NUM_PORTS*(DATA_W/8)  flattened byte enables; bit k enables byte k.
- resp_valid  out  NUM_PORTS  per-port read response strobe, 1 cycle wide.
- resp_data  out  NUM_PORTS*DATA_W  flattened read data; valid only while the matching resp_valid bit is 1.

Behaviour:
- Reset: resp_valid = 0, resp_data = 0, round-robin pointer = 0, read-latency pipeline cleared. Memory contents are not reset.
- Handshake:
  - A transfer occurs on port i when req_valid[i] and req_ready[i] are both 1 at a clock edge.
  - A requester holds valid, we, addr, wdata and be stable until it is granted.
  - At most one bit of req_ready is 1 in any cycle.
  - req_ready[i] is never 1 while req_valid[i] is 0.
- Arbitration:
  - Round-robin. Search starts at port (last_granted+1) mod NUM_PORTS; the first port with valid asserted is granted.
  - last_granted updates only on a transfer.
  - With no valid requests, no grant is issued and the pointer holds.
  - NUM_PORTS = 1: req_ready[0] = req_valid[0].
- Addressing: only the low DEPTH_LOG2 bits of the address are used. Upper bits are ignored, so addresses wrap modulo the depth.
- Write: on the transfer edge, byte k of the word is written when be[k] = 1; other bytes keep their value. No response is generated. be = 0 is a legal no-op write.
- Read:
  - Data is sampled from storage at the transfer edge, so a write completed at an earlier edge is visible.
  - The port index and data travel through an RD_LAT-deep pipeline.
  - resp_valid[i] rises exactly RD_LAT cycles after the transfer edge, for 1 cycle.
  - Reads complete in issue order; there is one response per read.
- Throughput: one transfer per cycle in total. Back-to-back reads give back-to-back responses, and pipelined reads to different ports overlap.
- Reset mid-operation: in-flight reads are dropped with no response. The pointer returns to 0, so port 0 has priority on the first post-reset cycle.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest port index wins. The round-robin pointer is not instantiated. All other behaviour is unchanged.
- Undefined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset then a single read: port 0 writes 0xDEADBEEF to addr 5 with be = 0xF, then reads addr 5 → resp_valid[0] asserts RD_LAT cycles after the read handshake with 0xDEADBEEF; resp_valid[1] stays 0.
- Byte enables: write 0x11223344 to addr 7 with be = 0xF, then 0xAABBCCDD with be = 0x5, then read → response 0x11BB33DD.
- Contention: ports 0 and 1 both hold read requests for 4 cycles → grants alternate 0,1,0,1. Under MEM_ARB_FIXED_PRIO_EN, port 0 is granted every cycle while valid and port 1 waits.
- Wrap: with DEPTH_LOG2 = 12, write 0x5 to addr 0x1003, then read addr 0x3 → response 0x5.
- RD_LAT = 3 pipelining: reads issued on consecutive cycles (port 0 to addr 1, port 1 to addr 2, port 0 to addr 3) → responses arrive on three consecutive cycles, in order, on the correct ports with the correct data.
- Reset mid-flight: with RD_LAT = 2, assert rst one cycle after a read handshake → no resp_valid appears afterwards, and port 0 is granted first after rst deasserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_PORTS valid/ready requesters sharing one word memory, one access per cycle
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_we per port;
//   req_addr/req_wdata/req_be flattened per port; resp_valid/resp_data flattened per port.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_be,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]     resp_data
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic                  gnt;
  logic [PW-1:0]         gnt_idx;
  logic [DEPTH_LOG2-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic [BE_W-1:0]       be;
  logic                  wr, rd;
  logic [RD_LAT-1:0]     pv;
  logic [PW-1:0]         pp [RD_LAT];
  logic [DATA_W-1:0]     pd [RD_LAT];
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end
`else
  // ptr is the first port searched, i.e. last granted + 1; reset to 0 gives port 0 first pick
  logic [PW-1:0] ptr;
  int idx;
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (req_valid[idx]) begin
        gnt = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (gnt) ptr <= gnt_idx == PW'(NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
`endif
  always_comb begin
    req_ready = '0;
    req_ready[gnt_idx] = gnt;
  end
  assign a  = req_addr[gnt_idx*ADDR_W +: DEPTH_LOG2];
  assign wd = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign be = req_be[gnt_idx*BE_W +: BE_W];
  assign wr = gnt & req_we[gnt_idx];
  assign rd = gnt & ~req_we[gnt_idx];
  // Storage and the read-data pipeline carry no reset; data is qualified by pv.
  always_ff @(posedge clk) begin
    if (wr)
      for (int k = 0; k < BE_W; k++)
        if (be[k]) mem[a][k*8 +: 8] <= wd[k*8 +: 8];
    pd[0] <= mem[a];
    for (int j = 1; j < RD_LAT; j++) pd[j] <= pd[j-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      for (int j = 0; j < RD_LAT; j++) pp[j] <= '0;
    end else begin
      pv[0] <= rd;
      pp[0] <= gnt_idx;
      for (int j = 1; j < RD_LAT; j++) begin
        pv[j] <= pv[j-1];
        pp[j] <= pp[j-1];
      end
    end
  always_comb begin
    resp_valid = '0;
    resp_data = '0;
    resp_valid[pp[RD_LAT-1]] = pv[RD_LAT-1];
    resp_data[pp[RD_LAT-1]*DATA_W +: DATA_W] = pv[RD_LAT-1] ? pd[RD_LAT-1] : '0;
  end
endmodule
